// File: rtl/fb_pkg.sv
// Shared types and helpers for the ping-pong video frame buffer.
// FB_CLEAR_EN adds the StClear state used to zero the back buffer after each swap.
package fb_pkg;

   localparam int unsigned DupW = 8;

   typedef enum logic [1:0] {
      StFill,
      StWaitSwap
`ifdef FB_CLEAR_EN
      , StClear
`endif
   } fb_state_e;

   // Linear pixel address; the constant width lets synthesis reduce this to shift-add.
   function automatic int unsigned fb_lin_addr(input int unsigned x, input int unsigned y,
                                               input int unsigned width);
      return y * width + x;
   endfunction

endpackage

// File: rtl/fb_bank_ram.sv
// Simple dual-port RAM holding both frame buffers; the address MSB selects the buffer.
// Registered read, one cycle latency, contents are not reset.
module fb_bank_ram #(
   parameter int unsigned AddrW = 16,
   parameter int unsigned DataW = 1
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AddrW-1:0] waddr_i,
   input  logic [DataW-1:0] wdata_i,
   input  logic             re_i,
   input  logic [AddrW-1:0] raddr_i,
   output logic [DataW-1:0] rdata_o
);

   logic [DataW-1:0] mem [2**AddrW];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_o <= mem[raddr_i];
      end
   end

endmodule

// File: rtl/video_fb_pingpong.sv
// Double-buffered frame store: writer fills the back buffer, swap happens only on vsync.
// Define FB_CLEAR_EN to zero the new back buffer after every swap.
module video_fb_pingpong
   import fb_pkg::*;
#(
   parameter int unsigned WIDTH    = 200,
   parameter int unsigned HEIGHT   = 150,
   parameter int unsigned PIX_BITS = 1,
   parameter int unsigned X_ADDRW  = $clog2(WIDTH),
   parameter int unsigned Y_ADDRW  = $clog2(HEIGHT),
   parameter int unsigned ADDRW    = $clog2(WIDTH * HEIGHT)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_valid,
   output logic                wr_ready,
   input  logic [X_ADDRW-1:0]  wr_x,
   input  logic [Y_ADDRW-1:0]  wr_y,
   input  logic [PIX_BITS-1:0] wr_data,
   input  logic                frame_done,
   input  logic                vsync_pulse,
   input  logic                rd_en,
   input  logic [X_ADDRW-1:0]  rd_x,
   input  logic [Y_ADDRW-1:0]  rd_y,
   output logic [PIX_BITS-1:0] rd_data,
   output logic                rd_valid,
   output logic                front_sel,
   output logic                swap_pending,
   output logic [DupW-1:0]     dup_count
);

   localparam int unsigned RamAw = ADDRW + 1;

   fb_state_e state_q, state_d;
   logic front_sel_q, front_sel_d;
   logic [DupW-1:0] dup_q, dup_d;
   logic swap, dup_inc;

   logic wr_in_range, rd_in_range;
   logic [ADDRW-1:0] wr_addr, rd_addr;

   logic ram_we;
   logic [RamAw-1:0] ram_waddr, ram_raddr;
   logic [PIX_BITS-1:0] ram_wdata, ram_rdata;

   logic rd_en_q, rd_oob_q, rd_valid_q;
   logic [PIX_BITS-1:0] rd_data_q;

`ifdef FB_CLEAR_EN
   localparam int unsigned Pixels = WIDTH * HEIGHT;
   localparam fb_state_e AfterSwap = StClear;

   logic [ADDRW-1:0] clr_addr_q, clr_addr_d;
   logic clr_last;

   // Entering StClear always comes from another state, so the counter starts at zero.
   assign clr_addr_d = (state_q == StClear) ? clr_addr_q + ADDRW'(1) : '0;
   assign clr_last   = (clr_addr_q == ADDRW'(Pixels - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         clr_addr_q <= '0;
      end else begin
         clr_addr_q <= clr_addr_d;
      end
   end
`else
   localparam fb_state_e AfterSwap = StFill;
`endif

   assign wr_in_range = (32'(wr_x) < WIDTH) && (32'(wr_y) < HEIGHT);
   assign rd_in_range = (32'(rd_x) < WIDTH) && (32'(rd_y) < HEIGHT);
   assign wr_addr     = ADDRW'(fb_lin_addr(32'(wr_x), 32'(wr_y), WIDTH));
   assign rd_addr     = ADDRW'(fb_lin_addr(32'(rd_x), 32'(rd_y), WIDTH));

   always_comb begin
      state_d     = state_q;
      front_sel_d = front_sel_q;
      dup_d       = dup_q;
      swap        = 1'b0;
      dup_inc     = 1'b0;
      case (state_q)
         StFill: begin
            if (frame_done && vsync_pulse) begin
               swap = 1'b1;
            end else if (frame_done) begin
               state_d = StWaitSwap;
            end else if (vsync_pulse) begin
               dup_inc = 1'b1;
            end
         end
         StWaitSwap: begin
            if (vsync_pulse) begin
               swap = 1'b1;
            end
         end
`ifdef FB_CLEAR_EN
         StClear: begin
            dup_inc = vsync_pulse;
            if (clr_last) begin
               state_d = StFill;
            end
         end
`endif
         default: state_d = StFill;
      endcase
      if (swap) begin
         front_sel_d = ~front_sel_q;
         state_d     = AfterSwap;
      end
      if (dup_inc && (dup_q != '1)) begin
         dup_d = dup_q + DupW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StFill;
         front_sel_q <= 1'b0;
         dup_q       <= '0;
      end else begin
         state_q     <= state_d;
         front_sel_q <= front_sel_d;
         dup_q       <= dup_d;
      end
   end

   // Out-of-range writes are handshaked but never reach the RAM.
   always_comb begin
      ram_we    = wr_valid && wr_ready && wr_in_range;
      ram_waddr = {~front_sel_q, wr_addr};
      ram_wdata = wr_data;
`ifdef FB_CLEAR_EN
      if (state_q == StClear) begin
         ram_we    = 1'b1;
         ram_waddr = {~front_sel_q, clr_addr_q};
         ram_wdata = '0;
      end
`endif
   end

   // Buffer index is captured with the read address, so a swap cannot redirect it.
   assign ram_raddr = {front_sel_q, rd_addr};

   fb_bank_ram #(
      .AddrW(RamAw),
      .DataW(PIX_BITS)
   ) u_ram (
      .clk_i  (clk),
      .we_i   (ram_we),
      .waddr_i(ram_waddr),
      .wdata_i(ram_wdata),
      .re_i   (rd_en),
      .raddr_i(ram_raddr),
      .rdata_o(ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_en_q    <= 1'b0;
         rd_oob_q   <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_en_q    <= rd_en;
         rd_oob_q   <= ~rd_in_range;
         rd_valid_q <= rd_en_q;
         rd_data_q  <= (rd_en_q && !rd_oob_q) ? ram_rdata : '0;
      end
   end

   assign wr_ready     = (state_q == StFill);
   assign swap_pending = (state_q == StWaitSwap);
   assign front_sel    = front_sel_q;
   assign dup_count    = dup_q;
   assign rd_valid     = rd_valid_q;
   assign rd_data      = rd_data_q;

endmodule
